row_norm_sqrt: RTL and testbench

//   Upstream stage of the norm divider in the FastICA weight-update path.

---
 rtl/row_norm_sqrt.sv | 192 +++++++++++++++++++
 tb/tb_row_norm_sqrt.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/row_norm_sqrt.sv
// Row-wise Euclidean norm of a 4x4 signed weight matrix: sequential sum of squares
// followed by a restoring bit-serial integer square root, clamped to the signed output range.
module row_norm_sqrt #(
    parameter int W = 26
) (
    input  logic                clk_sqrt,
    input  logic                rst_sqrt,
    input  logic                start_sqrt,
    input  logic signed [W-1:0] w_in11,
    input  logic signed [W-1:0] w_in12,
    input  logic signed [W-1:0] w_in13,
    input  logic signed [W-1:0] w_in14,
    input  logic signed [W-1:0] w_in21,
    input  logic signed [W-1:0] w_in22,
    input  logic signed [W-1:0] w_in23,
    input  logic signed [W-1:0] w_in24,
    input  logic signed [W-1:0] w_in31,
    input  logic signed [W-1:0] w_in32,
    input  logic signed [W-1:0] w_in33,
    input  logic signed [W-1:0] w_in34,
    input  logic signed [W-1:0] w_in41,
    input  logic signed [W-1:0] w_in42,
    input  logic signed [W-1:0] w_in43,
    input  logic signed [W-1:0] w_in44,
    output logic        [W-1:0] norm1,
    output logic        [W-1:0] norm2,
    output logic        [W-1:0] norm3,
    output logic        [W-1:0] norm4,
    output logic        [3:0]   zero_flag,
    output logic        [3:0]   sat_flag,
    output logic                busy,
    output logic                done
);

    localparam logic [1:0]   ST_IDLE     = 2'd0;
    localparam logic [1:0]   ST_SQ       = 2'd1;
    localparam logic [1:0]   ST_ROOT     = 2'd2;
    localparam logic [1:0]   ST_STORE    = 2'd3;
    localparam int           AW          = 2 * W + 2;
    localparam int           RW          = W + 4;
    localparam logic [4:0]   ROOT_LAST_C = 5'(W);
    localparam logic [W-1:0] NORM_MAX_C  = {1'b0, {(W-1){1'b1}}};

    logic [1:0]          state_r;
    logic [1:0]          row_r;
    logic [1:0]          col_r;
    logic [4:0]          step_r;
    logic signed [W-1:0] w_r [16];
    // Radicand doubles as the isqrt shift register; its top bit stays clear after accumulation.
    logic [AW-1:0]       acc_r;
    logic [RW-1:0]       rem_r;
    logic [W:0]          root_r;
    logic [W-1:0]        norm_sh_r [3];
    logic [2:0]          zero_sh_r;
    logic [2:0]          sat_sh_r;

    logic signed [W-1:0]   w_sel_s;
    logic signed [2*W-1:0] w_ext_s;
    logic signed [2*W-1:0] sq_s;
    logic [RW-1:0]         rem_shift_s;
    logic [RW-1:0]         trial_s;
    logic [RW-1:0]         rem_next_s;
    logic                  ge_s;
    logic                  sat_s;
    logic                  zero_s;
    logic [W-1:0]          norm_calc_s;

    // Square of the selected element, one isqrt step, and the clamp of the finished root
    always_comb begin
        w_sel_s     = w_r[{row_r, col_r}];
        w_ext_s     = {{W{w_sel_s[W-1]}}, w_sel_s};
        sq_s        = w_ext_s * w_ext_s;
        rem_shift_s = (rem_r << 2) | {{(RW-2){1'b0}}, acc_r[AW-1:AW-2]};
        trial_s     = {{(RW-W-3){1'b0}}, root_r, 2'b01};
        ge_s        = (rem_shift_s >= trial_s);
        if (ge_s) begin
            rem_next_s = rem_shift_s - trial_s;
        end else begin
            rem_next_s = rem_shift_s;
        end
        sat_s  = (root_r > {1'b0, NORM_MAX_C});
        zero_s = (root_r == {(W+1){1'b0}});
        if (sat_s) begin
            norm_calc_s = NORM_MAX_C;
        end else begin
            norm_calc_s = root_r[W-1:0];
        end
    end

    // Sequencer, datapath registers and coherent output update
    always_ff @(posedge clk_sqrt or posedge rst_sqrt) begin
        if (rst_sqrt) begin
            state_r   <= ST_IDLE;
            row_r     <= 2'd0;
            col_r     <= 2'd0;
            step_r    <= 5'd0;
            acc_r     <= {AW{1'b0}};
            rem_r     <= {RW{1'b0}};
            root_r    <= {(W+1){1'b0}};
            zero_sh_r <= 3'd0;
            sat_sh_r  <= 3'd0;
            for (int i = 0; i < 16; i++) w_r[i] <= {W{1'b0}};
            for (int i = 0; i < 3; i++) norm_sh_r[i] <= {W{1'b0}};
            norm1     <= {W{1'b0}};
            norm2     <= {W{1'b0}};
            norm3     <= {W{1'b0}};
            norm4     <= {W{1'b0}};
            zero_flag <= 4'd0;
            sat_flag  <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start_sqrt) begin
                        w_r[0]  <= w_in11;  w_r[1]  <= w_in12;  w_r[2]  <= w_in13;  w_r[3]  <= w_in14;
                        w_r[4]  <= w_in21;  w_r[5]  <= w_in22;  w_r[6]  <= w_in23;  w_r[7]  <= w_in24;
                        w_r[8]  <= w_in31;  w_r[9]  <= w_in32;  w_r[10] <= w_in33;  w_r[11] <= w_in34;
                        w_r[12] <= w_in41;  w_r[13] <= w_in42;  w_r[14] <= w_in43;  w_r[15] <= w_in44;
                        row_r   <= 2'd0;
                        col_r   <= 2'd0;
                        acc_r   <= {AW{1'b0}};
                        busy    <= 1'b1;
                        state_r <= ST_SQ;
                    end
                end
                ST_SQ: begin
                    acc_r <= acc_r + {2'b00, sq_s};
                    col_r <= col_r + 2'd1;
                    if (col_r == 2'd3) begin
                        rem_r   <= {RW{1'b0}};
                        root_r  <= {(W+1){1'b0}};
                        step_r  <= 5'd0;
                        state_r <= ST_ROOT;
                    end
                end
                ST_ROOT: begin
                    rem_r  <= rem_next_s;
                    root_r <= {root_r[W-1:0], ge_s};
                    acc_r  <= acc_r << 2;
                    step_r <= step_r + 5'd1;
                    if (step_r == ROOT_LAST_C) begin
                        state_r <= ST_STORE;
                    end
                end
                ST_STORE: begin
                    case (row_r)
                        2'd0: begin
                            norm_sh_r[0] <= norm_calc_s;
                            zero_sh_r[0] <= zero_s;
                            sat_sh_r[0]  <= sat_s;
                        end
                        2'd1: begin
                            norm_sh_r[1] <= norm_calc_s;
                            zero_sh_r[1] <= zero_s;
                            sat_sh_r[1]  <= sat_s;
                        end
                        2'd2: begin
                            norm_sh_r[2] <= norm_calc_s;
                            zero_sh_r[2] <= zero_s;
                            sat_sh_r[2]  <= sat_s;
                        end
                        default: begin
                            // Last row goes straight to the outputs alongside the shadowed rows.
                            norm1     <= norm_sh_r[0];
                            norm2     <= norm_sh_r[1];
                            norm3     <= norm_sh_r[2];
                            norm4     <= norm_calc_s;
                            zero_flag <= {zero_s, zero_sh_r};
                            sat_flag  <= {sat_s, sat_sh_r};
                            done      <= 1'b1;
                            busy      <= 1'b0;
                        end
                    endcase
                    row_r <= row_r + 2'd1;
                    col_r <= 2'd0;
                    acc_r <= {AW{1'b0}};
                    if (row_r == 2'd3) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_SQ;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_row_norm_sqrt.sv
// Self-checking bench for row_norm_sqrt: directed cases with literal expectations plus
// randomized matrices against a cycle-count/arithmetic reference model.
module tb_row_norm_sqrt;
    localparam int W = 26;

    typedef struct packed {
        logic [W-1:0] norm;
        logic         z;
        logic         s;
    } row_res_t;

    logic                clk_sqrt   = 1'b0;
    logic                rst_sqrt   = 1'b1;
    logic                start_sqrt = 1'b0;
    logic signed [W-1:0] w [16];
    logic [W-1:0]        norm1, norm2, norm3, norm4;
    logic [3:0]          zero_flag, sat_flag;
    logic                busy, done;

    logic                m_busy, m_done;
    int                  m_cnt;
    logic [W-1:0]        m_norm [4];
    logic [3:0]          m_zero, m_sat;
    row_res_t            m_pend [4];

    int   n_checks = 0;
    int   n_err    = 0;
    logic chk_en   = 1'b0;

    always #5 clk_sqrt = ~clk_sqrt;

    row_norm_sqrt #(.W(W)) dut (
        .clk_sqrt(clk_sqrt), .rst_sqrt(rst_sqrt), .start_sqrt(start_sqrt),
        .w_in11(w[0]),  .w_in12(w[1]),  .w_in13(w[2]),  .w_in14(w[3]),
        .w_in21(w[4]),  .w_in22(w[5]),  .w_in23(w[6]),  .w_in24(w[7]),
        .w_in31(w[8]),  .w_in32(w[9]),  .w_in33(w[10]), .w_in34(w[11]),
        .w_in41(w[12]), .w_in42(w[13]), .w_in43(w[14]), .w_in44(w[15]),
        .norm1(norm1), .norm2(norm2), .norm3(norm3), .norm4(norm4),
        .zero_flag(zero_flag), .sat_flag(sat_flag), .busy(busy), .done(done)
    );

    function automatic longint isqrt(input longint s);
        longint r;
        longint t;
        r = 0;
        for (int b = 27; b >= 0; b--) begin
            t = r | (longint'(1) << b);
            if (t * t <= s) r = t;
        end
        return r;
    endfunction

    function automatic row_res_t row_eval(input logic signed [W-1:0] a, b, c, d);
        longint xa, xb, xc, xd, root;
        row_res_t res;
        xa = longint'(a); xb = longint'(b); xc = longint'(c); xd = longint'(d);
        root  = isqrt(xa * xa + xb * xb + xc * xc + xd * xd);
        res.s = (root > 64'sd33554431);
        res.z = (root == 64'sd0);
        if (res.s) res.norm = 26'd33554431;
        else res.norm = root[W-1:0];
        return res;
    endfunction

    function automatic logic signed [W-1:0] rand_w();
        logic [31:0] t;
        case ($urandom_range(0, 3))
            0: begin t = $urandom; return t[W-1:0]; end
            1: begin t = $urandom_range(0, 6); return t[W-1:0] - 26'd3; end
            2: return '0;
            default: begin
                t = $urandom_range(0, 1);
                if (t[0]) return 26'h2000000;
                else return 26'h1FFFFFF;
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: accept in idle, results appear 128 edges after the accepting edge
    always @(posedge clk_sqrt or posedge rst_sqrt) begin
        if (rst_sqrt) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
            m_zero <= 4'd0;
            m_sat  <= 4'd0;
            for (int r = 0; r < 4; r++) m_norm[r] <= '0;
        end else if (!m_busy) begin
            m_done <= 1'b0;
            if (start_sqrt) begin
                m_busy <= 1'b1;
                m_cnt  <= 1;
                for (int r = 0; r < 4; r++)
                    m_pend[r] <= row_eval(w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]);
            end
        end else if (m_cnt == 128) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            for (int r = 0; r < 4; r++) begin
                m_norm[r] <= m_pend[r].norm;
                m_zero[r] <= m_pend[r].z;
                m_sat[r]  <= m_pend[r].s;
            end
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk_sqrt) begin
        if (chk_en) begin
            check("busy",      64'(busy),      64'(m_busy));
            check("done",      64'(done),      64'(m_done));
            check("norm1",     64'(norm1),     64'(m_norm[0]));
            check("norm2",     64'(norm2),     64'(m_norm[1]));
            check("norm3",     64'(norm3),     64'(m_norm[2]));
            check("norm4",     64'(norm4),     64'(m_norm[3]));
            check("zero_flag", 64'(zero_flag), 64'(m_zero));
            check("sat_flag",  64'(sat_flag),  64'(m_sat));
        end
    end

    task automatic set_row(input int r, input logic signed [W-1:0] a, b, c, d);
        w[4*r] = a; w[4*r+1] = b; w[4*r+2] = c; w[4*r+3] = d;
    endtask

    task automatic do_start();
        @(posedge clk_sqrt); #2 start_sqrt = 1'b1;
        @(posedge clk_sqrt); #2 start_sqrt = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_edges);
        int e;
        e = 0;
        while (done !== 1'b1 && e < 200) begin
            @(posedge clk_sqrt); #1;
            e++;
        end
        check(name, 64'(e), 64'(exp_edges));
        @(posedge clk_sqrt); #1;
        check({name, "_width"}, 64'(done), 64'd0);
    endtask

    initial begin
        int dones;
        int cyc;
        for (int i = 0; i < 16; i++) w[i] = '0;
        repeat (3) @(posedge clk_sqrt);
        #2;
        check("rst_busy",  64'(busy),      64'd0);
        check("rst_done",  64'(done),      64'd0);
        check("rst_norm1", 64'(norm1),     64'd0);
        check("rst_zero",  64'(zero_flag), 64'd0);
        check("rst_sat",   64'(sat_flag),  64'd0);
        rst_sqrt = 1'b0;
        chk_en   = 1'b1;

        // Basic latency and values
        set_row(0, 26'sd12582912, 26'sd16777216, 26'sd0, 26'sd0);
        for (int r = 1; r < 4; r++) set_row(r, 26'sd0, 26'sd0, 26'sd0, -26'sd7);
        do_start();
        wait_done("t1_latency", 128);
        check("t1_norm1", 64'(norm1), 64'd20971520);
        check("t1_norm2", 64'(norm2), 64'd7);
        check("t1_norm4", 64'(norm4), 64'd7);
        check("t1_flags", 64'({zero_flag, sat_flag}), 64'd0);

        // Saturation and floor rounding
        set_row(0, 26'h2000000, 26'h2000000, 26'h2000000, 26'h2000000);
        set_row(1, 26'sd1, 26'sd1, 26'sd0, 26'sd0);
        set_row(2, 26'sd0, 26'sd0, 26'sd0, 26'sd0);
        set_row(3, 26'sd0, 26'sd0, 26'sd0, 26'sd0);
        do_start();
        wait_done("t2_latency", 128);
        check("t2_norm1", 64'(norm1),     64'd33554431);
        check("t2_norm2", 64'(norm2),     64'd1);
        check("t2_sat",   64'(sat_flag),  64'd1);
        check("t2_zero",  64'(zero_flag), 64'd12);

        // Zero row flag
        set_row(0, 26'sd3, 26'sd4, 26'sd0, 26'sd0);
        set_row(1, 26'sd1, 26'sd2, 26'sd2, 26'sd0);
        set_row(2, 26'sd0, 26'sd0, 26'sd0, 26'sd0);
        set_row(3, 26'sd0, 26'sd0, 26'sd0, -26'sd9);
        do_start();
        wait_done("t3_latency", 128);
        check("t3_norm1", 64'(norm1),     64'd5);
        check("t3_norm2", 64'(norm2),     64'd3);
        check("t3_norm3", 64'(norm3),     64'd0);
        check("t3_norm4", 64'(norm4),     64'd9);
        check("t3_zero",  64'(zero_flag), 64'd4);
        check("t3_sat",   64'(sat_flag),  64'd0);

        // Start and input changes while busy are ignored
        set_row(0, 26'sd12582912, 26'sd16777216, 26'sd0, 26'sd0);
        for (int r = 1; r < 4; r++) set_row(r, 26'sd0, 26'sd0, 26'sd0, -26'sd7);
        do_start();
        repeat (50) @(posedge clk_sqrt);
        #2 start_sqrt = 1'b1;
        for (int i = 0; i < 16; i++) w[i] = rand_w();
        @(posedge clk_sqrt); #2 start_sqrt = 1'b0;
        check("t4_hold_norm1", 64'(norm1), 64'd5);
        check("t4_busy",       64'(busy),  64'd1);
        wait_done("t4_latency", 77);
        check("t4_norm1", 64'(norm1), 64'd20971520);
        check("t4_norm3", 64'(norm3), 64'd7);

        // Asynchronous reset mid-operation, then a clean rerun
        set_row(0, 26'h2000000, 26'h2000000, 26'h2000000, 26'h2000000);
        set_row(1, 26'sd1, 26'sd1, 26'sd0, 26'sd0);
        set_row(2, 26'sd0, 26'sd0, 26'sd0, 26'sd0);
        set_row(3, 26'sd0, 26'sd0, 26'sd0, 26'sd0);
        do_start();
        repeat (70) @(posedge clk_sqrt);
        #2 rst_sqrt = 1'b1;
        #1;
        check("t5_rst_norm1", 64'(norm1), 64'd0);
        check("t5_rst_busy",  64'(busy),  64'd0);
        check("t5_rst_done",  64'(done),  64'd0);
        repeat (2) @(posedge clk_sqrt);
        #2 rst_sqrt = 1'b0;
        do_start();
        wait_done("t5_latency", 128);
        check("t5_norm1", 64'(norm1),     64'd33554431);
        check("t5_norm2", 64'(norm2),     64'd1);
        check("t5_sat",   64'(sat_flag),  64'd1);
        check("t5_zero",  64'(zero_flag), 64'd12);

        // Random matrices, random start requests and input churn
        dones = 0;
        cyc   = 0;
        while (dones < 500 && cyc < 85000) begin
            @(posedge clk_sqrt); #2;
            cyc++;
            if (m_done) dones++;
            start_sqrt = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0)
                for (int i = 0; i < 16; i++) w[i] = rand_w();
        end
        start_sqrt = 1'b0;
        check("random_done_count", 64'(dones), 64'd500);
        repeat (2) @(posedge clk_sqrt);
        #2;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
